// File: rtl/rv32i_types.sv
// Shared types for the L1/L2 line-port scheduler: address word, line width and scheduler FSM states.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  localparam int L1_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    GNT_P = 2'd3
  } l1_sched_state_t;

endpackage

// File: rtl/l1_sched_starve_ctr.sv
// Saturating count of dcache grants completed while an icache request is waiting.
module l1_sched_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear takes precedence so that entering the icache grant always restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_W)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_W);

endmodule

// File: rtl/l1_mem_scheduler.sv
// Shares the single L2 line port between icache, dcache and next-line prefetcher, one transaction at a time.
// Prefetch arbitration is only built when L1_SCHED_PREFETCH_EN is defined; otherwise the pf port is inert.
module l1_mem_scheduler
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_W       = L1_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  rv32i_word         i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  rv32i_word         d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  input  logic              pf_read,
  input  rv32i_word         pf_addr,
  output logic [LINE_W-1:0] pf_rdata,
  output logic              pf_resp,
  output logic              mem_read,
  output logic              mem_write,
  output rv32i_word         mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  l1_sched_state_t   state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  rv32i_word         mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              d_req, pf_req, force_i;
  logic              starve_inc, starve_clr, at_limit;

  assign d_req   = d_read | d_write;
  assign force_i = i_read & at_limit;

`ifdef L1_SCHED_PREFETCH_EN
  assign pf_req = pf_read;
`else
  logic unused_pf_read;
  assign unused_pf_read = pf_read;
  assign pf_req         = 1'b0;
`endif

  // Winner's request is latched on leaving IDLE and held untouched until mem_resp.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && !force_i) begin
          state_d     = GNT_D;
          mem_write_d = d_write;
          mem_read_d  = ~d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_write ? d_wdata : '0;
        end else if (i_read) begin
          state_d     = GNT_I;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
        end else if (pf_req) begin
          state_d     = GNT_P;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = pf_addr;
          mem_wdata_d = '0;
        end
      end
      default: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign starve_inc = (state_q == GNT_D) & mem_resp & i_read;
  assign starve_clr = (state_q == IDLE) & (state_d == GNT_I);

  l1_sched_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(at_limit)
  );

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign i_resp  = (state_q == GNT_I) & mem_resp;
  assign i_rdata = (state_q == GNT_I) ? mem_rdata : '0;
  assign d_resp  = (state_q == GNT_D) & mem_resp;
  assign d_rdata = (state_q == GNT_D) ? mem_rdata : '0;

`ifdef L1_SCHED_PREFETCH_EN
  assign pf_resp  = (state_q == GNT_P) & mem_resp;
  assign pf_rdata = (state_q == GNT_P) ? mem_rdata : '0;
`else
  assign pf_resp  = 1'b0;
  assign pf_rdata = '0;
`endif

endmodule

// File: tb/tb_l1_mem_scheduler.sv
// Scoreboard bench for l1_mem_scheduler; prefetch expectations follow L1_SCHED_PREFETCH_EN.
module tb_l1_mem_scheduler;
  import rv32i_types::*;

  localparam int STARVE_LIMIT = 4;
  localparam int LINE_W       = 256;
`ifdef L1_SCHED_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  logic clk, rst;
  logic i_read, i_resp, d_read, d_write, d_resp, pf_read, pf_resp;
  logic mem_read, mem_write, mem_resp;
  rv32i_word i_addr, d_addr, pf_addr, mem_addr;
  logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata, pf_rdata, mem_wdata, mem_rdata;

  l1_mem_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pf_read(pf_read), .pf_addr(pf_addr), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    int                port;  // 0 icache, 1 dcache, 2 prefetch
    bit                wr;
    rv32i_word         addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  exp_t expq[$];
  int checks = 0, passed = 0;
  int cyc = 0, scen_start = 0, scen_resp = 0, last_resp = 0;
  int model_cnt = 0, lat = 0;
  bit mem_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // L2 responder: answers each transaction after a random 0..3 cycle wait with random line data.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_en) begin
        if (mem_resp) begin
          mem_resp  = 1'b0;
          mem_rdata = '0;
        end else if (mem_read || mem_write) begin
          if (lat == 0) begin
            mem_resp = 1'b1;
            for (int k = 0; k < LINE_W / 32; k++) mem_rdata[k*32 +: 32] = $urandom;
            lat = $urandom_range(0, 3);
          end else begin
            lat--;
          end
        end
      end
    end
  end

  // Monitor: timing of grants, grant hold, and every completion against the scoreboard.
  logic prev_active = 1'b0, prev_rd, prev_wr;
  rv32i_word prev_addr;
  logic [LINE_W-1:0] prev_wdata;
  exp_t e;
  int port;
  always @(negedge clk) begin
    if (rst) begin
      prev_active = 1'b0;
    end else begin
      if ((mem_read || mem_write) && !prev_active) begin
        if (scen_resp > 0) checkOutput("req_gap", cyc - last_resp, 2);
        else checkOutput("req_latency", cyc - scen_start, 1);
      end
      if ((mem_read || mem_write) && prev_active) begin
        checkOutput("grant_hold", {mem_read, mem_write, mem_addr}, {prev_rd, prev_wr, prev_addr});
        checkOutput("grant_hold_wdata", mem_wdata, prev_wdata);
      end
      if (i_resp || d_resp || pf_resp) begin
        checkOutput("resp_onehot", 32'(i_resp) + 32'(d_resp) + 32'(pf_resp), 1);
        if (expq.size() == 0) begin
          checkOutput("unexpected_resp", {i_resp, d_resp, pf_resp}, 0);
        end else begin
          e = expq.pop_front();
          port = i_resp ? 0 : (d_resp ? 1 : 2);
          checkOutput("resp_port", port, e.port);
          checkOutput("op_write", mem_write, e.wr);
          checkOutput("op_read", mem_read, !e.wr);
          checkOutput("addr", mem_addr, e.addr);
          if (e.wr) checkOutput("wdata", mem_wdata, e.wdata);
          checkOutput("i_rdata", i_rdata, (port == 0) ? mem_rdata : '0);
          checkOutput("d_rdata", d_rdata, (port == 1) ? mem_rdata : '0);
          checkOutput("pf_rdata", pf_rdata, (port == 2) ? mem_rdata : '0);
        end
        scen_resp++;
        last_resp = cyc;
      end
      prev_active = mem_read || mem_write;
      prev_rd     = mem_read;
      prev_wr     = mem_write;
      prev_addr   = mem_addr;
      prev_wdata  = mem_wdata;
    end
  end

  // One scenario: requests raised together, dcache re-requests n_d times back to back, each held until served.
  task automatic applyStimulus(input bit has_i, input int n_d, input int d_op, input bit has_pf,
                               input rv32i_word ia, input rv32i_word da, input rv32i_word pa,
                               input logic [LINE_W-1:0] dw);
    bit pend_i = has_i, pend_p = has_pf && PF_EN;
    int dk = 0, exp_n = 0, got = 0, tmo = 0, didx = 0;
    bit ri, rd, rp;
    exp_t x;
    while (pend_i || dk < n_d || pend_p) begin
      if (dk < n_d && !(pend_i && model_cnt == STARVE_LIMIT)) begin
        x.port = 1; x.wr = (d_op != 0); x.addr = da + 32'(32 * dk);
        x.wdata = dw ^ LINE_W'(dk);
        if (pend_i && model_cnt < STARVE_LIMIT) model_cnt++;
        dk++;
      end else if (pend_i) begin
        x.port = 0; x.wr = 1'b0; x.addr = ia; x.wdata = '0;
        model_cnt = 0; pend_i = 1'b0;
      end else begin
        x.port = 2; x.wr = 1'b0; x.addr = pa; x.wdata = '0;
        pend_p = 1'b0;
      end
      expq.push_back(x);
      exp_n++;
    end
    @(posedge clk); #1;
    scen_start = cyc; scen_resp = 0;
    i_read = has_i; i_addr = ia;
    pf_read = has_pf; pf_addr = pa;
    d_addr = da; d_wdata = dw;
    d_read = (n_d > 0) && (d_op != 1);
    d_write = (n_d > 0) && (d_op != 0);
    while (got < exp_n && tmo < 400) begin
      @(negedge clk);
      tmo++;
      ri = i_resp; rd = d_resp; rp = pf_resp;
      got += int'(ri) + int'(rd) + int'(rp);
      @(posedge clk); #1;
      if (ri) i_read = 1'b0;
      if (rp) pf_read = 1'b0;
      if (rd) begin
        didx++;
        if (didx < n_d) begin
          d_addr = da + 32'(32 * didx);
          d_wdata = dw ^ LINE_W'(didx);
        end else begin
          d_read = 1'b0; d_write = 1'b0;
        end
      end
    end
    checkOutput("scenario_done", got, exp_n);
    checkOutput("queue_drained", expq.size(), 0);
    expq.delete();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pf_read = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int n, bad;
    bit ri;
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pf_read = 1'b0;
    i_addr = '0; d_addr = '0; pf_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_resps", {i_resp, d_resp, pf_resp}, 0);
    checkOutput("rst_rdatas", i_rdata | d_rdata | pf_rdata, 0);
    mem_en = 1'b1;

    lat = 2;
    applyStimulus(1'b1, 0, 0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, '0);
    applyStimulus(1'b1, 1, 1, 1'b0, 32'h0000_0080, 32'h0000_0100, 32'h0, {32{8'hA5}});
    applyStimulus(1'b1, 6, 0, 1'b0, 32'h0000_1000, 32'h0000_2000, 32'h0, '0);
    applyStimulus(1'b1, 6, 1, 1'b0, 32'h0000_3000, 32'h0000_4000, 32'h0, {32{8'h3C}});
    applyStimulus(1'b0, 1, 2, 1'b0, 32'h0, 32'h0000_0500, 32'h0, {32{8'h5A}});

    if (PF_EN) begin
      applyStimulus(1'b0, 0, 0, 1'b1, 32'h0, 32'h0, 32'h0000_0200, '0);
    end else begin
      @(posedge clk); #1;
      pf_read = 1'b1; pf_addr = 32'h0000_0200;
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (mem_read || mem_write || pf_resp) bad++;
      end
      checkOutput("pf_ignored", bad, 0);
      @(posedge clk); #1 pf_read = 1'b0;
    end

    // Reset in the middle of a dcache grant, followed by a stale response.
    mem_en = 1'b0;
    @(posedge clk); #1;
    scen_start = cyc; scen_resp = 0;
    d_read = 1'b1; d_addr = 32'h0000_0300;
    n = 0;
    while (!mem_read && n < 5) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_test_grant", mem_read, 1);
    @(posedge clk); #1;
    rst = 1'b1; d_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    checkOutput("midrst_mem_op", {mem_read, mem_write}, 0);
    checkOutput("midrst_mem_addr", mem_addr, 0);
    checkOutput("midrst_no_resp", {i_resp, d_resp, pf_resp}, 0);
    @(posedge clk); #1;
    mem_resp = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checkOutput("midrst_stays_idle", {mem_read, mem_write}, 0);
    model_cnt = 0; lat = 0;
    mem_en = 1'b1;

    for (int s = 0; s < 40; s++) begin
      ri = 1'($urandom % 2);
      n = $urandom_range(0, 6);
      if (!ri && n == 0) ri = 1'b1;
      applyStimulus(ri, n, $urandom_range(0, 2), 1'($urandom % 2),
                    $urandom & 32'hFFFF_FFE0, $urandom & 32'hFFFF_0FE0, $urandom & 32'hFFFF_FFE0,
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
